// File: rtl/apollo_13_pio_arbiter_pkg.sv
// Shared types and constants for the PIO arbiter slice.
package apollo_13_pio_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam int         PIO_W         = 4;

endpackage

// File: rtl/apollo_13_pio_arbiter_if.sv
// Avalon-MM master bus toward the PIO slave port s1.
interface apollo_13_pio_arbiter_if;

    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata
    );

endinterface

// File: rtl/apollo_13_pio_arbiter_rr_arbiter.sv
// Combinational rotate-priority picker: first set req bit after rr_ptr, wrapping.
module apollo_13_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         rr_ptr,
    output logic               grant_valid,
    output logic [2:0]         grant_idx
);

    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        // Walk from farthest to nearest so the nearest hit is the one that sticks.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/apollo_13_pio_arbiter.sv
// Round-robin Avalon-MM master sharing the PIO output register among NUM_REQ requesters.
// Optional readback verify enabled by APOLLO_13_PIO_ARB_READBACK_EN.
module apollo_13_pio_arbiter
    import apollo_13_pio_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = PIO_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic                      verify_err,
    apollo_13_pio_arbiter_if.master   avm
);

    state_t            state;
    logic [2:0]        rr_ptr;
    logic              grant_valid;
    logic [2:0]        grant_idx;
    logic [DATA_W-1:0] sel_data;

    apollo_13_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign sel_data        = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    assign avm.avm_address = PIO_DATA_ADDR;

`ifdef APOLLO_13_PIO_ARB_READBACK_EN
    logic unused_rd;
    assign unused_rd = ^avm.avm_readdata[31:DATA_W];
`else
    logic unused_rd;
    assign unused_rd = ^avm.avm_readdata;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            ack                <= '0;
            grant_id           <= '0;
            busy               <= 1'b0;
            verify_err         <= 1'b0;
            rr_ptr             <= 3'(NUM_REQ-1);
            avm.avm_chipselect <= 1'b0;
            avm.avm_write_n    <= 1'b1;
            avm.avm_writedata  <= '0;
        end else begin
            ack        <= '0;
            verify_err <= 1'b0;
            case (state)
                IDLE: if (grant_valid) begin
                    state              <= WRITE;
                    busy               <= 1'b1;
                    grant_id           <= grant_idx;
                    avm.avm_chipselect <= 1'b1;
                    avm.avm_write_n    <= 1'b0;
                    // writedata doubles as the latched value for the rest of the transaction
                    avm.avm_writedata  <= {{(32-DATA_W){1'b0}}, sel_data};
                end
`ifdef APOLLO_13_PIO_ARB_READBACK_EN
                WRITE: begin
                    state           <= READ;
                    avm.avm_write_n <= 1'b1;
                end
                READ: begin
                    state              <= ACK;
                    avm.avm_chipselect <= 1'b0;
                    ack                <= NUM_REQ'(1) << grant_id;
                    verify_err         <= avm.avm_readdata[DATA_W-1:0] != avm.avm_writedata[DATA_W-1:0];
                end
`else
                WRITE: begin
                    state              <= ACK;
                    avm.avm_chipselect <= 1'b0;
                    avm.avm_write_n    <= 1'b1;
                    ack                <= NUM_REQ'(1) << grant_id;
                end
`endif
                ACK: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    rr_ptr <= grant_id;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apollo_13_pio_arbiter.sv
// Randomized self-checking bench for apollo_13_pio_arbiter against a transaction-timeline model.
module tb_apollo_13_pio_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;
`ifdef APOLLO_13_PIO_ARB_READBACK_EN
    localparam int ACKOFF = 3;
`else
    localparam int ACKOFF = 2;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    ack;
    logic [2:0]      grant_id;
    logic            busy, verify_err;
    logic            force_rd = 1'b0;
    logic [31:0]     force_val = '0;
    logic [DW-1:0]   pio;

    apollo_13_pio_arbiter_if bus();

    apollo_13_pio_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .grant_id   (grant_id),
        .busy       (busy),
        .verify_err (verify_err),
        .avm        (bus)
    );

    always #5 clk = ~clk;

    // PIO slave: output register at offset 0, cleared by the shared reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pio <= '0;
        else if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd0)
            pio <= bus.avm_writedata[DW-1:0];
    end
    assign bus.avm_readdata = force_rd ? force_val : {{(32-DW){1'b0}}, pio};

    int errs = 0, checks = 0, cyc = 0, wr_cnt = 0;
    int m_start = -100, m_win = 0, m_last = N-1, m_gid = 0;
    bit m_act = 0;
    logic [DW-1:0] m_data = '0;
    int ack_log[$], pio_log[$], cyc_log[$], verr_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last+k)%N]) return (last+k)%N;
        return 0;
    endfunction

    // One clock: model samples the same inputs the DUT samples, then outputs are checked.
    task automatic step();
        logic [N-1:0] e_ack;
        logic e_cs, e_wn, e_busy, e_verr;
        if (reset_n && (!m_act || cyc > m_start+ACKOFF) && req != '0) begin
            m_win   = pick(req, m_last);
            m_data  = req_data[m_win*DW +: DW];
            m_start = cyc;
            m_act   = 1;
        end
        @(posedge clk);
        cyc++;
        #1;
        e_cs   = m_act && (cyc == m_start+1 || (ACKOFF == 3 && cyc == m_start+2));
        e_wn   = !(m_act && cyc == m_start+1);
        e_ack  = (m_act && cyc == m_start+ACKOFF) ? N'(1) << m_win : '0;
        e_busy = m_act && cyc > m_start && cyc <= m_start+ACKOFF;
        e_verr = 1'b0;
`ifdef APOLLO_13_PIO_ARB_READBACK_EN
        if (m_act && cyc == m_start+ACKOFF)
            e_verr = (force_rd ? force_val[DW-1:0] : m_data) != m_data;
`endif
        if (m_act && cyc == m_start+1) m_gid = m_win;
        if (m_act && cyc == m_start+ACKOFF) m_last = m_win;
        chk("chipselect", bus.avm_chipselect, e_cs);
        chk("write_n", bus.avm_write_n, e_wn);
        chk("address", bus.avm_address, 0);
        chk("ack", ack, e_ack);
        chk("busy", busy, e_busy);
        chk("grant_id", grant_id, m_gid);
        chk("verify_err", verify_err, e_verr);
        if (e_cs && !e_wn) chk("writedata", bus.avm_writedata, {{(32-DW){1'b0}}, m_data});
        if (bus.avm_chipselect && !bus.avm_write_n) wr_cnt++;
        if (ack != '0) begin
            for (int i = 0; i < N; i++) if (ack[i]) ack_log.push_back(i);
            pio_log.push_back(int'(pio));
            cyc_log.push_back(cyc);
            verr_log.push_back(int'(verify_err));
            req &= ~ack;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_act = 0; m_gid = 0; m_last = N-1;
        #1;
        chk("rst_chipselect", bus.avm_chipselect, 0);
        chk("rst_write_n", bus.avm_write_n, 1);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_verify_err", verify_err, 0);
        chk("rst_writedata", bus.avm_writedata, 0);
        chk("rst_pio", pio, 0);
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic clear_logs();
        ack_log.delete(); pio_log.delete(); cyc_log.delete(); verr_log.delete();
    endtask

    initial begin
        bit hit;
        int wr0;
        #2;
        do_reset();

        // single request from requester 0
        clear_logs();
        req = 4'b0001; req_data = 16'h000A;
        repeat (ACKOFF+1) step();
        chk("t1_acks", ack_log.size(), 1);
        if (ack_log.size() == 1) begin
            chk("t1_idx", ack_log[0], 0);
            chk("t1_pio", pio_log[0], 32'hA);
        end

        // all four requesting: strict rotation from reset
        do_reset();
        clear_logs();
        req = 4'b1111; req_data = 16'h4321;
        repeat (4*(ACKOFF+1)) step();
        chk("t2_acks", ack_log.size(), 4);
        if (ack_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_order", ack_log[i], i);
                chk("t2_pio", pio_log[i], i+1);
            end
            for (int i = 1; i < 4; i++) chk("t2_spacing", cyc_log[i]-cyc_log[i-1], ACKOFF+1);
        end

        // wrap: grant 2, then 0101 must go 0 then 2
        clear_logs();
        req = 4'b0100;
        repeat (ACKOFF+1) step();
        req = 4'b0101;
        repeat (2*(ACKOFF+1)) step();
        chk("t3_acks", ack_log.size(), 3);
        if (ack_log.size() == 3) begin
            chk("t3_first", ack_log[0], 2);
            chk("t3_wrap", ack_log[1], 0);
            chk("t3_next", ack_log[2], 2);
        end

        // reset during WRITE aborts; pointer returns to NUM_REQ-1
        clear_logs();
        req = 4'b0010; req_data = 16'h00F0;
        hit = 0;
        for (int i = 0; i < 4 && !hit; i++) begin
            step();
            hit = bus.avm_chipselect && !bus.avm_write_n;
        end
        chk("t4_write_seen", hit, 1);
        do_reset();
        chk("t4_no_ack", ack_log.size(), 0);
        req = 4'b1010;
        repeat (2*(ACKOFF+1)) step();
        chk("t4_acks", ack_log.size(), 2);
        if (ack_log.size() == 2) begin
            chk("t4_after_rst", ack_log[0], 1);
            chk("t4_then", ack_log[1], 3);
        end

`ifdef APOLLO_13_PIO_ARB_READBACK_EN
        // readback mismatch then match
        clear_logs();
        force_rd = 1'b1; force_val = 32'h5;
        req = 4'b0001; req_data = 16'h0003;
        repeat (ACKOFF+1) step();
        force_rd = 1'b0;
        req = 4'b0001;
        repeat (ACKOFF+1) step();
        chk("t5_acks", verr_log.size(), 2);
        if (verr_log.size() == 2) begin
            chk("t5_mismatch", verr_log[0], 1);
            chk("t5_match", verr_log[1], 0);
        end
`endif

        // one-cycle request pulse still completes exactly once
        clear_logs();
        wr0 = wr_cnt;
        req = 4'b0001; req_data = 16'h0007;
        step();
        req = '0;
        repeat (8) step();
        chk("t6_writes", wr_cnt - wr0, 1);
        chk("t6_acks", ack_log.size(), 1);
        chk("t6_pio", pio, 4'h7);

        // random traffic with data churn, drops and readback forcing
        for (int it = 0; it < 400; it++) begin
            req_data = (N*DW)'($urandom);
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
            if ($urandom_range(0, 15) == 0) req[$urandom_range(0, N-1)] = 1'b0;
`ifdef APOLLO_13_PIO_ARB_READBACK_EN
            force_rd  = $urandom_range(0, 1) == 1;
            force_val = $urandom;
`endif
            step();
        end
        req = '0;
        repeat (ACKOFF+2) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/apollo_13_pio_arbiter.md
Name: apollo_13_pio_arbiter

Overview:
- Avalon-MM master that shares the 4-bit LED/status PIO output register between NUM_REQ on-chip requesters.
- Arbitrates round-robin, then issues one single-cycle write to PIO address 0 on behalf of the winner.
- Acknowledges the winner with a one-cycle pulse.
- Sits between the requesters and the PIO slave port s1, in place of a direct CPU-only connection.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- DATA_W, 4: PIO output width; bits driven into writedata[DATA_W-1:0].

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  level request, one bit per requester; held until the matching ack.
- req_data  input  NUM_REQ*DATA_W  write value; requester i occupies slice [i*DATA_W +: DATA_W].
- ack  output  NUM_REQ  one-cycle completion pulse, one-hot.
- grant_id  output  3  index of the current or last granted requester.
- busy  output  1  high whenever the state is not IDLE.
- verify_err  output  1  readback mismatch, valid with ack; tied 0 when the feature is off.
- avm_address  output  2  PIO address, always 0 when active.
- avm_chipselect  output  1  slave select.
- avm_write_n  output  1  active-low write strobe.
- avm_writedata  output  32  {zero-extend, latched data}.
- avm_readdata  input  32  PIO readdata (combinational, zero wait states).

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE; ack=0; grant_id=0; busy=0; verify_err=0; avm_chipselect=0; avm_write_n=1; avm_address=0; avm_writedata=0; rr_ptr=NUM_REQ-1.
- IDLE:
  - If req!=0, select the first set bit searching from rr_ptr+1, wrapping modulo NUM_REQ.
  - Latch that requester's req_data slice and index; go to WRITE.
  - Otherwise stay in IDLE.
- WRITE, exactly 1 cycle: avm_chipselect=1, avm_write_n=0, avm_address=0, avm_writedata={28'b0, data}.
  - Next state is ACK, or READ when the feature is enabled.
- ACK, 1 cycle: ack[grant_id]=1; rr_ptr<=grant_id; bus deasserted (chipselect=0, write_n=1); then IDLE.
- Latency:
  - req seen in IDLE at cycle 0; write strobe on the bus in cycle 1; ack in cycle 2 (cycle 3 with readback).
  - Next grant is possible in cycle 3.
- Requester contract: drop req on the clock edge that samples ack=1. A req still high in the IDLE after its own ack is treated as a new request.
- Fairness: a continuously requesting set is served in strict rotation; no requester waits more than NUM_REQ-1 grants.
- req deasserted mid-transaction: the latched transaction still completes and ack still pulses.
- req_data changing after the IDLE sample has no effect on the write.
- Simultaneous requests: resolved only by rr_ptr; the first grant after reset goes to the lowest index.
- Async reset mid-transaction: abort immediately to reset values with no ack. Any partially issued write is cleared by the same reset in the PIO.
- Address is never nonzero; other PIO offsets are never accessed.

Optional Feature:
- Macro: APOLLO_13_PIO_ARB_READBACK_EN.
- When defined:
  - WRITE goes to READ: chipselect=1, write_n=1, address=0 for 1 cycle.
  - At the end of READ, register verify_err <= (avm_readdata[DATA_W-1:0] != latched data).
  - verify_err is asserted coincident with ack and cleared the cycle after.
- When undefined: no READ state, verify_err is constant 0, avm_readdata is unused.

Decomposition:
- Shared package apollo_13_pio_pkg:
  - state enum {IDLE, WRITE, READ, ACK}.
  - Constants PIO_DATA_ADDR=2'd0 and PIO_W=4.
- One natural sub-module, apollo_13_rr_arbiter: combinational rotate-priority picker taking req and rr_ptr, returning grant_valid and grant_idx. The FSM and pointer register stay in the top level.

Test Plan:
- Reset, then req=4'b0001, data0=4'hA -> cycle 1: chipselect=1, write_n=0, writedata=32'h0000000A; cycle 2: ack=4'b0001; PIO reads back 4'hA.
- req=4'b1111 held, each requester dropping on its own ack, data i=i+1 -> grant order 0,1,2,3; PIO values 1,2,3,4; one ack every 3 cycles.
- After a grant to 2, req=4'b0101 -> grant 0 next (wrap), then 2.
- reset_n low during WRITE -> same cycle: chipselect=0, write_n=1, no ack; after release, rr_ptr=3 and PIO=0.
- With the macro, force avm_readdata=32'h5 while writing 4'h3 -> ack with verify_err=1; with matching readback -> verify_err=0; ack at cycle 3.
- req pulsed for only 1 cycle with data 4'h7 -> write still issued and ack pulses; no second write follows.
